// File: rtl/fpu_cvt_pkg.sv
// Shared types for the int32->float16 converter writeback slice.
package fpu_cvt_pkg;

  localparam logic [15:0] NAN_BOX16 = 16'hFFFF;
  localparam int          RD_W      = 5;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
  } wb_entry_t;

  typedef enum logic {
    IDLE,
    HOLD
  } cvt_state_t;

endpackage

// File: rtl/fpu_cvt_wb_if.sv
// Converter-result input stream and register-file write stream of the writeback stage.
interface fpu_cvt_wb_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [15:0]           in_result;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [4:0]            in_flags;
  logic                  in_pack;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [31:0]           wb_data;

  modport master (
    output in_valid, in_result, in_rd, in_flags, in_pack, wb_ready,
    input  in_ready, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  in_valid, in_result, in_rd, in_flags, in_pack, wb_ready,
    output in_ready, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/fpu_sync_fifo.sv
// Small synchronous FIFO with flush; head reads as zero while empty.
module fpu_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/fpu_cvt_wb.sv
// Writeback stage: NaN-boxes or pairs float16 results, queues register writes, keeps sticky fflags.
module fpu_cvt_wb
  import fpu_cvt_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = RD_W
) (
  input  logic          CLK,
  input  logic          nRST,
  fpu_cvt_wb_if.slave   bus,
  input  logic          flush,
  output logic [4:0]    fflags,
  input  logic          fflags_clr,
  output logic          busy
);
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [31:0]           data;
  } entry_t;

  cvt_state_t            state_reg;
  logic [REG_ADDR_W-1:0] hold_rd_reg;
  logic [15:0]           hold_result_reg;
  fflags_t               fflags_reg;

  entry_t push_entry;
  entry_t head_entry;
  logic   push;
  logic   accept;
  logic   fifo_full;
  logic   fifo_empty;

  assign bus.in_ready = !fifo_full && !flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // The second beat of a pair lands in the upper half; its own rd is dropped.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (accept) begin
      if (state_reg == HOLD) begin
        push            = 1'b1;
        push_entry.rd   = hold_rd_reg;
        push_entry.data = {bus.in_result, hold_result_reg};
      end else if (!bus.in_pack) begin
        push            = 1'b1;
        push_entry.rd   = bus.in_rd;
        push_entry.data = {NAN_BOX16, bus.in_result};
      end
    end
  end

  fpu_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (nRST),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (bus.wb_valid && bus.wb_ready),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.wb_valid = !fifo_empty;
  assign bus.wb_rd    = head_entry.rd;
  assign bus.wb_data  = head_entry.data;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg       <= IDLE;
      hold_rd_reg     <= '0;
      hold_result_reg <= '0;
    end else if (flush) begin
      state_reg       <= IDLE;
      hold_rd_reg     <= '0;
      hold_result_reg <= '0;
    end else if (accept) begin
      case (state_reg)
        IDLE: begin
          if (bus.in_pack) begin
            state_reg       <= HOLD;
            hold_rd_reg     <= bus.in_rd;
            hold_result_reg <= bus.in_result;
          end
        end
        HOLD: begin
          state_reg       <= IDLE;
          hold_rd_reg     <= '0;
          hold_result_reg <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Clear takes priority, but a same-cycle accept still deposits its flags.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fflags_reg <= '0;
    end else if (fflags_clr) begin
      fflags_reg <= accept ? fflags_t'(bus.in_flags) : '0;
    end else if (accept) begin
      fflags_reg <= fflags_t'(fflags_reg | bus.in_flags);
    end
  end

  assign fflags = fflags_reg;
  assign busy   = (state_reg == HOLD) || !fifo_empty;

endmodule

// File: tb/tb_fpu_cvt_wb.sv
// Randomized and directed bench for fpu_cvt_wb against a queue-based reference model.
module tb_fpu_cvt_wb;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       fflags_clr = 1'b0;
  logic [4:0] fflags;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  fpu_cvt_wb_if #(.REG_ADDR_W(5)) bus ();

  fpu_cvt_wb #(.DEPTH(DEPTH), .REG_ADDR_W(5)) dut (
    .CLK        (clk),
    .nRST       (rst_n),
    .bus        (bus),
    .flush      (flush),
    .fflags     (fflags),
    .fflags_clr (fflags_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: pending writes as {rd, data}, plus the held low half.
  logic [36:0] exp_q[$];
  bit          m_held;
  logic [4:0]  m_held_rd;
  logic [15:0] m_held_res;
  logic [4:0]  m_fflags;

  task automatic model_reset();
    exp_q.delete();
    m_held     = 0;
    m_held_rd  = '0;
    m_held_res = '0;
    m_fflags   = '0;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_result = '0;
    bus.in_rd     = '0;
    bus.in_flags  = '0;
    bus.in_pack   = 1'b0;
    flush         = 1'b0;
    fflags_clr    = 1'b0;
  endtask

  task automatic beat(input logic [15:0] res, input logic [4:0] rd,
                      input logic [4:0] flg, input logic pack);
    bus.in_valid  = 1'b1;
    bus.in_result = res;
    bus.in_rd     = rd;
    bus.in_flags  = flg;
    bus.in_pack   = pack;
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic tick();
    bit          m_ready;
    bit          acc;
    bit          pop;
    logic [36:0] e;
    m_ready = (exp_q.size() < DEPTH) && !flush;
    acc     = bus.in_valid && m_ready;
    pop     = (exp_q.size() != 0) && bus.wb_ready && !flush;
    if (flush) begin
      exp_q.delete();
      m_held = 0;
    end else begin
      if (pop) begin
        e = exp_q.pop_front();
        $display("txn write rd=%0d data=%h", e[36:32], e[31:0]);
      end
      if (acc) begin
        if (m_held) begin
          exp_q.push_back({m_held_rd, bus.in_result, m_held_res});
          m_held = 0;
        end else if (bus.in_pack) begin
          m_held     = 1;
          m_held_rd  = bus.in_rd;
          m_held_res = bus.in_result;
        end else begin
          exp_q.push_back({bus.in_rd, 16'hFFFF, bus.in_result});
        end
      end
    end
    if (fflags_clr) m_fflags = acc ? bus.in_flags : 5'b0;
    else if (acc)   m_fflags = m_fflags | bus.in_flags;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.wb_ready = 1'b0;
    rst_n = 1'b0;
    beat(16'h1234, 5'd1, 5'b11111, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", bus.wb_valid); end
    checks++; if (fflags !== 5'b0) begin errors++; $display("FAIL reset_fflags got %b exp 00000", fflags); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({bus.wb_rd, bus.wb_data} !== 37'b0) begin errors++; $display("FAIL reset_wb_head got %h exp 0", {bus.wb_rd, bus.wb_data}); end
    rst_n = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    $display("txn reset released");
  endtask

  task automatic test_single();
    bus.wb_ready = 1'b1;
    beat(16'h3C00, 5'd5, 5'b0, 1'b0);
    tick();
    idle_inputs();
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.wb_valid); end
    checks++; if (bus.wb_data !== 32'hFFFF3C00) begin errors++; $display("FAIL single_data got %h exp FFFF3C00", bus.wb_data); end
    checks++; if (bus.wb_rd !== 5'd5) begin errors++; $display("FAIL single_rd got %0d exp 5", bus.wb_rd); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drain got valid=%b busy=%b exp 0 0", bus.wb_valid, busy); end
  endtask

  task automatic test_pair();
    bus.wb_ready = 1'b1;
    beat(16'h4000, 5'd3, 5'b0, 1'b1);
    tick();
    idle_inputs();
    checks++; if (busy !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL pair_hold got busy=%b valid=%b exp 1 0", busy, bus.wb_valid); end
    tick();
    beat(16'hC000, 5'd7, 5'b0, 1'b0);
    tick();
    idle_inputs();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hC0004000) begin errors++; $display("FAIL pair_data got valid=%b data=%h exp 1 C0004000", bus.wb_valid, bus.wb_data); end
    checks++; if (bus.wb_rd !== 5'd3) begin errors++; $display("FAIL pair_rd got %0d exp 3", bus.wb_rd); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL pair_single_write got valid=%b busy=%b exp 0 0", bus.wb_valid, busy); end
  endtask

  task automatic test_backpressure();
    logic [15:0] res[5];
    logic [36:0] got[$];
    bit          sent5;
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      res[i] = 16'($urandom);
      beat(res[i], 5'(10 + i), 5'b0, 1'b0);
      #1;
      checks++; if (bus.in_ready !== (i < DEPTH)) begin errors++; $display("FAIL bp_in_ready beat %0d got %b exp %b", i, bus.in_ready, (i < DEPTH)); end
      tick();
    end
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.wb_data !== {16'hFFFF, res[0]}) begin errors++; $display("FAIL bp_head got %h exp %h", bus.wb_data, {16'hFFFF, res[0]}); end
    bus.wb_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      if (bus.wb_valid) got.push_back({bus.wb_rd, bus.wb_data});
      sent5 = bus.in_valid && (exp_q.size() < DEPTH);
      tick();
      if (sent5) bus.in_valid = 1'b0;
    end
    idle_inputs();
    checks++; if (got.size() != 5) begin errors++; $display("FAIL bp_write_count got %0d exp 5", got.size()); end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== {5'(10 + k), 16'hFFFF, res[k]}) begin
        errors++; $display("FAIL bp_order write %0d got %h exp %h", k, got[k], {5'(10 + k), 16'hFFFF, res[k]});
      end
    end
  endtask

  task automatic test_flags();
    bus.wb_ready = 1'b1;
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    beat(16'h0001, 5'd1, 5'b00001, 1'b0);
    tick();
    beat(16'h0002, 5'd2, 5'b00100, 1'b0);
    tick();
    idle_inputs();
    checks++; if (fflags !== 5'b00101) begin errors++; $display("FAIL flags_accum got %b exp 00101", fflags); end
    fflags_clr = 1'b1;
    beat(16'h0003, 5'd3, 5'b00010, 1'b0);
    tick();
    idle_inputs();
    checks++; if (fflags !== 5'b00010) begin errors++; $display("FAIL flags_clr_set got %b exp 00010", fflags); end
    tick();
    checks++; if (fflags !== 5'b00010) begin errors++; $display("FAIL flags_sticky got %b exp 00010", fflags); end
    tick();
  endtask

  task automatic setup_hold_two();
    bus.wb_ready = 1'b0;
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    beat(16'hAAAA, 5'd4, 5'b10000, 1'b0);
    tick();
    beat(16'hBBBB, 5'd6, 5'b0, 1'b0);
    tick();
    beat(16'hCCCC, 5'd8, 5'b0, 1'b1);
    tick();
    idle_inputs();
  endtask

  task automatic test_flush();
    setup_hold_two();
    checks++; if (busy !== 1'b1 || bus.wb_valid !== 1'b1) begin errors++; $display("FAIL flush_setup got busy=%b valid=%b exp 1 1", busy, bus.wb_valid); end
    flush = 1'b1;
    bus.wb_ready = 1'b1;
    beat(16'hDDDD, 5'd9, 5'b01000, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", bus.in_ready); end
    tick();
    idle_inputs();
    checks++; if (bus.wb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_empty got valid=%b busy=%b exp 0 0", bus.wb_valid, busy); end
    checks++; if (fflags !== 5'b10000) begin errors++; $display("FAIL flush_fflags got %b exp 10000", fflags); end
    beat(16'h1234, 5'd9, 5'b0, 1'b0);
    tick();
    idle_inputs();
    checks++; if (bus.wb_data !== 32'hFFFF1234 || bus.wb_rd !== 5'd9) begin errors++; $display("FAIL flush_idle got rd=%0d data=%h exp 9 FFFF1234", bus.wb_rd, bus.wb_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    setup_hold_two();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.wb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_empty got valid=%b busy=%b exp 0 0", bus.wb_valid, busy); end
    checks++; if (fflags !== 5'b0) begin errors++; $display("FAIL rstmid_fflags got %b exp 00000", fflags); end
    checks++; if ({bus.wb_rd, bus.wb_data} !== 37'b0) begin errors++; $display("FAIL rstmid_head got %h exp 0", {bus.wb_rd, bus.wb_data}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    bus.wb_ready = 1'b1;
    beat(16'h5555, 5'd2, 5'b0, 1'b0);
    tick();
    idle_inputs();
    checks++; if (bus.wb_data !== 32'hFFFF5555) begin errors++; $display("FAIL rstmid_idle got %h exp FFFF5555", bus.wb_data); end
    tick();
  endtask

  task automatic test_random();
    logic [36:0] exp_head;
    for (int n = 0; n < 400; n++) begin
      beat(16'($urandom), 5'($urandom), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.wb_ready = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 31) == 0);
      fflags_clr   = ($urandom_range(0, 15) == 0);
      #1;
      exp_head = (exp_q.size() != 0) ? exp_q[0] : 37'b0;
      checks++; if (bus.in_ready !== ((exp_q.size() < DEPTH) && !flush)) begin errors++; $display("FAIL rnd_in_ready cycle %0d got %b", n, bus.in_ready); end
      checks++; if (bus.wb_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_wb_valid cycle %0d got %b exp %b", n, bus.wb_valid, exp_q.size() != 0); end
      checks++; if ({bus.wb_rd, bus.wb_data} !== exp_head) begin errors++; $display("FAIL rnd_head cycle %0d got %h exp %h", n, {bus.wb_rd, bus.wb_data}, exp_head); end
      checks++; if (busy !== (m_held || exp_q.size() != 0)) begin errors++; $display("FAIL rnd_busy cycle %0d got %b", n, busy); end
      checks++; if (fflags !== m_fflags) begin errors++; $display("FAIL rnd_fflags cycle %0d got %b exp %b", n, fflags, m_fflags); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    bus.wb_ready = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_single();
    test_pair();
    test_backpressure();
    test_flags();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
